// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory-access stage and MEM/WB pipeline register. Issues a
//                registered load/store request to data memory, freezes the
//                upstream pipeline until the access is acknowledged, formats
//                load data and captures the write-back fields.
//                Optional feature: define MEM_TIMEOUT_EN to abandon accesses
//                after 255 unacknowledged wait cycles and raise mem_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        memtoreg_reg,
    input  logic        reg_write_reg,
    input  logic        mem_read_reg,
    input  logic        mem_write_reg,
    input  logic        halt_reg,
    input  logic        word_en_reg,
    input  logic        ld_en_reg,
    input  logic [15:0] alu_out_reg,
    input  logic [15:0] reg_out_reg,
    input  logic [2:0]  instr_rd_reg,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        dmem_byte,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_halt,
    output logic        mem_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_mem_op;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_load_data;

    assign w_mem_op = mem_read_reg | mem_write_reg;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_to_cnt;
    logic       r_mem_err;

    // The counter value 255 in an unacknowledged wait cycle abandons the access.
    assign w_timeout = (r_state == S_WAIT) && !dmem_ack && (r_to_cnt == 8'hFF);

    // Wait-cycle counter (cleared when the access is issued) and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= 8'h00;
            r_mem_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_mem_op) begin
                r_to_cnt <= 8'h00;
            end else if (r_state == S_WAIT && !dmem_ack && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Next-state logic and upstream freeze; ack is ignored while idle.
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_mem_op;
                if (w_mem_op) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = !dmem_ack && !w_timeout;
                if (dmem_ack || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory request register: loaded when an access is issued, strobes
    // dropped on completion; a simultaneous read and write keeps only the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_addr  <= 16'h0000;
            dmem_wdata <= 16'h0000;
            dmem_rd    <= 1'b0;
            dmem_wr    <= 1'b0;
            dmem_byte  <= 1'b0;
        end else if (r_state == S_IDLE && w_mem_op) begin
            dmem_addr  <= alu_out_reg;
            dmem_wdata <= word_en_reg ? reg_out_reg : {2{reg_out_reg[7:0]}};
            dmem_rd    <= mem_read_reg & ~mem_write_reg;
            dmem_wr    <= mem_write_reg;
            dmem_byte  <= ~word_en_reg;
        end else if (r_state == S_WAIT && (dmem_ack || w_timeout)) begin
            dmem_rd    <= 1'b0;
            dmem_wr    <= 1'b0;
        end
    end

    // Load formatting: odd addresses select the upper byte lane.
    always_comb begin
        w_byte      = alu_out_reg[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
        w_load_data = dmem_rdata;
        if (!word_en_reg) begin
            w_load_data = ld_en_reg ? {{8{w_byte[7]}}, w_byte} : {8'h00, w_byte};
        end
    end

    // MEM/WB register: capture when the stage advances, otherwise insert a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data      <= 16'h0000;
            wb_rd        <= 3'd0;
            wb_reg_write <= 1'b0;
            wb_halt      <= 1'b0;
        end else if (stall || w_timeout) begin
            wb_reg_write <= 1'b0;
            wb_halt      <= 1'b0;
        end else begin
            wb_data      <= memtoreg_reg ? w_load_data : alu_out_reg;
            wb_rd        <= instr_rd_reg;
            wb_reg_write <= reg_write_reg;
            wb_halt      <= halt_reg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage. Directed and random
//                instructions are issued one at a time; expected behaviour is
//                derived per transaction from the stage's timing rules.
//                Timeout checks are included when MEM_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        memtoreg_reg, reg_write_reg, mem_read_reg, mem_write_reg;
    logic        halt_reg, word_en_reg, ld_en_reg;
    logic [15:0] alu_out_reg, reg_out_reg;
    logic [2:0]  instr_rd_reg;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_rd, dmem_wr, dmem_byte, dmem_ack;
    logic        stall;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        wb_reg_write, wb_halt, mem_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: the last captured write-back fields (held across bubbles).
    logic [15:0] m_wb_data;
    logic [2:0]  m_wb_rd;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .memtoreg_reg  (memtoreg_reg),
        .reg_write_reg (reg_write_reg),
        .mem_read_reg  (mem_read_reg),
        .mem_write_reg (mem_write_reg),
        .halt_reg      (halt_reg),
        .word_en_reg   (word_en_reg),
        .ld_en_reg     (ld_en_reg),
        .alu_out_reg   (alu_out_reg),
        .reg_out_reg   (reg_out_reg),
        .instr_rd_reg  (instr_rd_reg),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rd       (dmem_rd),
        .dmem_wr       (dmem_wr),
        .dmem_byte     (dmem_byte),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_halt       (wb_halt),
        .mem_err       (mem_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Load value as seen by the register file.
    function automatic logic [15:0] ref_load(input logic [15:0] rdata, input logic [15:0] addr,
                                             input bit word, input bit sext);
        int b;
        if (word) return rdata;
        b = (int'(addr) % 2 == 1) ? (int'(rdata) / 256) : (int'(rdata) % 256);
        if (sext && b >= 128) return 16'(b - 256);
        return 16'(b);
    endfunction

    // Store data as presented on the memory bus.
    function automatic logic [15:0] ref_wdata(input logic [15:0] regv, input bit word);
        if (word) return regv;
        return 16'((int'(regv) % 256) * 257);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        memtoreg_reg = 1'b0; reg_write_reg = 1'b0; mem_read_reg = 1'b0; mem_write_reg = 1'b0;
        halt_reg = 1'b0; word_en_reg = 1'b0; ld_en_reg = 1'b0;
        alu_out_reg = 16'h0; reg_out_reg = 16'h0; instr_rd_reg = 3'd0;
        dmem_rdata = 16'h0; dmem_ack = 1'b0;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_wb_reg_write"}, 16'(wb_reg_write), 16'd0);
        chk({tag, "_wb_halt"},      16'(wb_halt),      16'd0);
        chk({tag, "_wb_data"},      wb_data,           m_wb_data);
        chk({tag, "_wb_rd"},        16'(wb_rd),        16'(m_wb_rd));
    endtask

    task automatic chk_capture(input string tag, input logic [15:0] d, input logic [2:0] rd,
                               input bit rw, input bit hl);
        m_wb_data = d;
        m_wb_rd   = rd;
        chk({tag, "_wb_data"},      wb_data,           d);
        chk({tag, "_wb_rd"},        16'(wb_rd),        16'(rd));
        chk({tag, "_wb_reg_write"}, 16'(wb_reg_write), 16'(rw));
        chk({tag, "_wb_halt"},      16'(wb_halt),      16'(hl));
    endtask

    // Issue one instruction (entered #1 after a posedge) and follow it to write-back.
    // delay = the WAIT cycle (1-based) in which memory acknowledges.
    task automatic run_op(input string tag, input bit rd_op, input bit wr_op, input bit word,
                          input bit sext, input bit rw, input bit hl,
                          input logic [15:0] alu, input logic [15:0] regv, input logic [2:0] rd,
                          input logic [15:0] rdata, input int delay);
        bit          load;
        logic [15:0] exp_d;
        load          = rd_op && !wr_op;
        memtoreg_reg  = load;
        reg_write_reg = rw;
        mem_read_reg  = rd_op;
        mem_write_reg = wr_op;
        halt_reg      = hl;
        word_en_reg   = word;
        ld_en_reg     = sext;
        alu_out_reg   = alu;
        reg_out_reg   = regv;
        instr_rd_reg  = rd;
        dmem_rdata    = 16'($urandom);
        dmem_ack      = 1'($urandom_range(0, 1));   // any ack while idle is ignored
        #4;
        chk({tag, "_idle_rd"}, 16'(dmem_rd), 16'd0);
        chk({tag, "_idle_wr"}, 16'(dmem_wr), 16'd0);
        chk({tag, "_idle_stall"}, 16'(stall), 16'(rd_op || wr_op));
        step();
        if (!(rd_op || wr_op)) begin
            chk_capture(tag, alu, rd, rw, hl);
        end else begin
            chk_bubble({tag, "_issue"});
            for (int k = 1; k <= delay; k++) begin
                dmem_ack   = (k == delay);
                dmem_rdata = (k == delay) ? rdata : 16'($urandom);
                #4;
                chk({tag, "_stall"}, 16'(stall), 16'(k < delay));
                chk({tag, "_dmem_rd"}, 16'(dmem_rd), 16'(load));
                chk({tag, "_dmem_wr"}, 16'(dmem_wr), 16'(wr_op));
                chk({tag, "_dmem_byte"}, 16'(dmem_byte), 16'(!word));
                chk({tag, "_dmem_addr"}, dmem_addr, alu);
                if (wr_op) chk({tag, "_dmem_wdata"}, dmem_wdata, ref_wdata(regv, word));
                step();
                if (k < delay) begin
                    chk_bubble({tag, "_wait"});
                end else begin
                    exp_d = load ? ref_load(rdata, alu, word, sext) : alu;
                    chk_capture(tag, exp_d, rd, rw, hl);
                end
            end
            dmem_ack = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        bit rd_op, wr_op;
        int stall_cycles;
        bit timed_out;

        clear_inputs();
        rst = 1'b1;
        step();
        step();
        #4;
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_wb_rd", 16'(wb_rd), 16'd0);
        chk("rst_wb_reg_write", 16'(wb_reg_write), 16'd0);
        chk("rst_wb_halt", 16'(wb_halt), 16'd0);
        chk("rst_dmem_rd", 16'(dmem_rd), 16'd0);
        chk("rst_dmem_wr", 16'(dmem_wr), 16'd0);
        chk("rst_mem_err", 16'(mem_err), 16'd0);
        chk("rst_stall", 16'(stall), 16'd0);
        rst = 1'b0;
        m_wb_data = 16'h0;
        m_wb_rd   = 3'd0;
        step();

        // Directed cases.
        run_op("alu",        0, 0, 1, 0, 1, 0, 16'h1234, 16'h0000, 3'd3, 16'h0000, 1);
        run_op("ld_word",    1, 0, 1, 0, 1, 0, 16'h0040, 16'h0000, 3'd5, 16'hBEEF, 3);
        run_op("ld_byte_s",  1, 0, 0, 1, 1, 0, 16'h0041, 16'h0000, 3'd2, 16'h80FF, 1);
        run_op("ld_byte_z",  1, 0, 0, 0, 1, 0, 16'h0041, 16'h0000, 3'd2, 16'h80FF, 2);
        run_op("ld_byte_lo", 1, 0, 0, 1, 1, 0, 16'h0042, 16'h0000, 3'd1, 16'h7F80, 1);
        run_op("st_rdwr",    1, 1, 0, 0, 0, 0, 16'h0010, 16'h12AB, 3'd4, 16'h0000, 1);
        run_op("halt",       0, 0, 1, 0, 0, 1, 16'h0007, 16'h0000, 3'd7, 16'h0000, 1);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            kind  = int'($urandom_range(0, 3));
            rd_op = (kind == 1) || (kind == 3);
            wr_op = (kind == 2) || (kind == 3);
            run_op("rnd", rd_op, wr_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
                   int'($urandom_range(1, 4)));
        end

        // Reset during the second wait cycle aborts the access; a late ack does nothing.
        mem_read_reg = 1'b1; memtoreg_reg = 1'b1; reg_write_reg = 1'b1; word_en_reg = 1'b1;
        alu_out_reg = 16'h0080; instr_rd_reg = 3'd6;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        dmem_ack = 1'b1;
        dmem_rdata = 16'h5555;
        #4;
        chk("abort_dmem_rd", 16'(dmem_rd), 16'd0);
        chk("abort_dmem_wr", 16'(dmem_wr), 16'd0);
        chk("abort_stall", 16'(stall), 16'd0);
        chk("abort_wb_data", wb_data, 16'h0);
        chk("abort_wb_rd", 16'(wb_rd), 16'd0);
        chk("abort_wb_reg_write", 16'(wb_reg_write), 16'd0);
        chk("abort_wb_halt", 16'(wb_halt), 16'd0);
        step();
        dmem_ack = 1'b0;
        chk("late_ack_wb_reg_write", 16'(wb_reg_write), 16'd0);
        chk("late_ack_wb_data", wb_data, 16'h0);
        m_wb_data = 16'h0;
        m_wb_rd   = 3'd0;
        run_op("post_abort", 0, 0, 1, 0, 1, 0, 16'hA5A5, 16'h0000, 3'd1, 16'h0000, 1);

`ifdef MEM_TIMEOUT_EN
        // Never acknowledge: after 255 stalled wait cycles the access is abandoned.
        mem_read_reg = 1'b1; memtoreg_reg = 1'b1; reg_write_reg = 1'b1; word_en_reg = 1'b1;
        halt_reg = 1'b1; alu_out_reg = 16'h0100; instr_rd_reg = 3'd2;
        step();
        stall_cycles = 0;
        timed_out    = 1'b0;
        for (int c = 0; c < 400 && !timed_out; c++) begin
            #4;
            if (stall) begin
                stall_cycles++;
                step();
            end else begin
                timed_out = 1'b1;
            end
        end
        chk("to_reached", 16'(timed_out), 16'd1);
        chk("to_wait_cycles", 16'(stall_cycles), 16'd255);
        chk("to_stall", 16'(stall), 16'd0);
        step();
        clear_inputs();
        chk("to_mem_err", 16'(mem_err), 16'd1);
        chk("to_bubble_reg_write", 16'(wb_reg_write), 16'd0);
        chk("to_bubble_halt", 16'(wb_halt), 16'd0);
        chk("to_dmem_rd", 16'(dmem_rd), 16'd0);
        step();
        step();
        chk("to_mem_err_sticky", 16'(mem_err), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("to_mem_err_cleared", 16'(mem_err), 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
